// File: rtl/change_pkg.sv
// Shared coin-handling definitions: FSM state encodings and coin denominations.
// Also used by the vending-machine block.
package change_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StIssue  = 3'd2,
    StDone   = 3'd3
  } state_e;

  localparam int unsigned NumCoins = 4;

  localparam logic [7:0] Coin50 = 8'd50;
  localparam logic [7:0] Coin10 = 8'd10;
  localparam logic [7:0] Coin5  = 8'd5;
  localparam logic [7:0] Coin1  = 8'd1;

  // Index 0 is the largest denomination; selection priority follows index order.
  function automatic logic [7:0] coin_value(input int idx);
    case (idx)
      0:       coin_value = Coin50;
      1:       coin_value = Coin10;
      2:       coin_value = Coin5;
      default: coin_value = Coin1;
    endcase
  endfunction

endpackage

// File: rtl/coin_selector.sv
// Combinational pick of the largest available denomination not exceeding remaining.
module coin_selector
  import change_pkg::*;
(
  input  logic [7:0]          remaining,
  input  logic [NumCoins-1:0] avail,
  output logic [7:0]          coin,
  output logic                none_found
);

  // Scan smallest to largest so the largest eligible coin is the last write.
  always_comb begin
    coin       = '0;
    none_found = 1'b1;
    for (int i = NumCoins - 1; i >= 0; i--) begin
      if (avail[i] && (coin_value(i) <= remaining)) begin
        coin       = coin_value(i);
        none_found = 1'b0;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out a requested amount one coin at a time over a
// valid/ready hopper handshake. Define CHANGE_INVENTORY_EN for finite per-coin stock.
module change_dispenser
  import change_pkg::*;
#(
  parameter logic [7:0] INV_INIT = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  output logic       coin_valid,
  output logic [7:0] coin_out,
  input  logic       coin_ready,
  output logic       done,
  output logic       short,
  output logic [7:0] remaining,
  output logic [7:0] coin_total,
  output logic [2:0] state
);

`ifdef CHANGE_INVENTORY_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [7:0]    coin_total_q, coin_total_d;
  logic [7:0]    coin_q, coin_d;
  logic          short_q, short_d;
  logic [NumCoins-1:0] avail;
  logic [7:0]    sel_coin;
  logic          sel_none;
  logic          handshake;

  coin_selector u_coin_selector (
    .remaining  (remaining_q),
    .avail      (avail),
    .coin       (sel_coin),
    .none_found (sel_none)
  );

  assign handshake = (state_q == StIssue) && coin_ready;

`ifdef CHANGE_INVENTORY_EN
  logic [NumCoins-1:0][7:0] stock_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stock_q <= {NumCoins{INV_INIT}};
    end else if (handshake) begin
      for (int i = 0; i < NumCoins; i++) begin
        if (coin_q == coin_value(i)) begin
          stock_q[i] <= stock_q[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < NumCoins; i++) begin
      avail[i] = (stock_q[i] != 8'd0);
    end
  end
`else
  assign avail = '1;
`endif

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_total_d = coin_total_q;
    coin_d       = coin_q;
    short_d      = short_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          remaining_d  = req_amount;
          coin_total_d = '0;
          short_d      = 1'b0;
          coin_d       = '0;
          state_d      = (req_amount == 8'd0) ? StDone : StSelect;
        end
      end
      StSelect: begin
        // Only reachable with finite stock: nothing left that fits the balance.
        if (sel_none) begin
          short_d = 1'b1;
          state_d = StDone;
        end else begin
          coin_d  = sel_coin;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (coin_ready) begin
          remaining_d  = remaining_q - coin_q;
          coin_total_d = coin_total_q + 8'd1;
          state_d      = (remaining_d == 8'd0) ? StDone : StSelect;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      coin_total_q <= '0;
      coin_q       <= '0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_total_q <= coin_total_d;
      coin_q       <= coin_d;
      short_q      <= short_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign coin_valid = (state_q == StIssue);
  assign coin_out   = coin_valid ? coin_q : 8'd0;
  assign done       = (state_q == StDone);
  assign short      = InvEn && done && short_q;
  assign remaining  = remaining_q;
  assign coin_total = coin_total_q;
  assign state      = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       coin_valid;
  logic [7:0] coin_out;
  logic       coin_ready;
  logic       done;
  logic       short;
  logic [7:0] remaining;
  logic [7:0] coin_total;
  logic [2:0] state;

  int vectors = 0;
  int errors  = 0;

  // Results of the most recent run_req call.
  logic [7:0] coin_log [16];
  int         n_coins;
  int         valid_cycles;
  int         done_cyc;

  change_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .coin_valid (coin_valid),
    .coin_out   (coin_out),
    .coin_ready (coin_ready),
    .done       (done),
    .short      (short),
    .remaining  (remaining),
    .coin_total (coin_total),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and follows it to done; records coins handed over.
  task automatic run_req(input logic [7:0] amt, input bit hold);
    for (int w = 0; w < 4 && !req_ready; w++) tick();
    req_valid  = 1'b1;
    req_amount = amt;
    n_coins      = 0;
    valid_cycles = 0;
    done_cyc     = -1;
    for (int c = 1; c <= 600; c++) begin
      tick();
      if (hold) req_amount = 8'd99;
      else      req_valid  = 1'b0;
      if (coin_valid) valid_cycles++;
      if (coin_valid && coin_ready) begin
        if (n_coins < 16) coin_log[n_coins] = coin_out;
        n_coins++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", req_ready); end
    vectors++; if (coin_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", coin_valid); end
    vectors++; if (coin_out !== 8'd0) begin errors++; $display("FAIL rst_coin: got %0d expected 0", coin_out); end
    vectors++; if (done !== 1'b0 || short !== 1'b0) begin errors++; $display("FAIL rst_done_short: got %0b%0b expected 00", done, short); end
    vectors++; if (remaining !== 8'd0 || coin_total !== 8'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", remaining, coin_total); end
    tick();
    reset = 1'b1;
    tick();
    vectors++; if (state !== 3'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_release: got state %0d ready %0b expected 0 1", state, req_ready); end
  endtask

  task automatic test_zero();
    coin_ready = 1'b1;
    run_req(8'd0, 1'b0);
    vectors++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", done_cyc); end
    vectors++; if (valid_cycles !== 0) begin errors++; $display("FAIL zero_valid: got %0d expected 0", valid_cycles); end
    vectors++; if (coin_total !== 8'd0 || remaining !== 8'd0) begin errors++; $display("FAIL zero_counts: got %0d/%0d expected 0/0", coin_total, remaining); end
    tick();
    vectors++; if (done !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL zero_pulse: got done %0b state %0d expected 0 0", done, state); end
  endtask

  // Holds req_valid with a different amount while busy; it must be ignored.
  task automatic test_greedy_66();
    logic [7:0] exp [4];
    exp[0] = 8'd50; exp[1] = 8'd10; exp[2] = 8'd5; exp[3] = 8'd1;
    coin_ready = 1'b1;
    run_req(8'd66, 1'b1);
    vectors++; if (n_coins !== 4) begin errors++; $display("FAIL g66_ncoins: got %0d expected 4", n_coins); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (coin_log[i] !== exp[i]) begin errors++; $display("FAIL g66_coin%0d: got %0d expected %0d", i, coin_log[i], exp[i]); end
    end
    vectors++; if (valid_cycles !== 4) begin errors++; $display("FAIL g66_valid_cycles: got %0d expected 4", valid_cycles); end
    vectors++; if (done_cyc !== 9) begin errors++; $display("FAIL g66_latency: got %0d expected 9", done_cyc); end
    vectors++; if (coin_total !== 8'd4 || remaining !== 8'd0) begin errors++; $display("FAIL g66_counts: got %0d/%0d expected 4/0", coin_total, remaining); end
    vectors++; if (short !== 1'b0) begin errors++; $display("FAIL g66_short: got %0b expected 0", short); end
    tick();
    vectors++; if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL g66_idle: got state %0d done %0b expected 0 0", state, done); end
  endtask

  task automatic test_stall_15();
    coin_ready = 1'b0;
    req_valid  = 1'b1;
    req_amount = 8'd15;
    tick();
    req_valid = 1'b0;
    vectors++; if (state !== 3'd1 || coin_valid !== 1'b0) begin errors++; $display("FAIL st_select: got state %0d valid %0b expected 1 0", state, coin_valid); end
    for (int s = 0; s < 3; s++) begin
      tick();
      vectors++;
      if (coin_valid !== 1'b1 || coin_out !== 8'd10) begin
        errors++; $display("FAIL st_hold%0d: got valid %0b coin %0d expected 1 10", s, coin_valid, coin_out);
      end
    end
    coin_ready = 1'b1;
    tick();
    vectors++; if (coin_valid !== 1'b0 || remaining !== 8'd5 || coin_total !== 8'd1) begin
      errors++; $display("FAIL st_after1: got valid %0b rem %0d total %0d expected 0 5 1", coin_valid, remaining, coin_total);
    end
    tick();
    vectors++; if (coin_valid !== 1'b1 || coin_out !== 8'd5) begin errors++; $display("FAIL st_coin2: got valid %0b coin %0d expected 1 5", coin_valid, coin_out); end
    tick();
    vectors++; if (done !== 1'b1 || coin_total !== 8'd2 || remaining !== 8'd0) begin
      errors++; $display("FAIL st_done: got done %0b total %0d rem %0d expected 1 2 0", done, coin_total, remaining);
    end
    tick();
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic test_inventory();
    coin_ready = 1'b1;
    for (int r = 0; r < 4; r++) run_req(8'd250, 1'b0);  // spends all 20 fifties
    run_req(8'd60, 1'b0);
    vectors++; if (n_coins !== 6) begin errors++; $display("FAIL inv60_ncoins: got %0d expected 6", n_coins); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (coin_log[i] !== 8'd10) begin errors++; $display("FAIL inv60_coin%0d: got %0d expected 10", i, coin_log[i]); end
    end
    vectors++; if (done !== 1'b1 || short !== 1'b0 || remaining !== 8'd0) begin
      errors++; $display("FAIL inv60_done: got done %0b short %0b rem %0d expected 1 0 0", done, short, remaining);
    end
    for (int r = 0; r < 20; r++) run_req(8'd6, 1'b0);  // spends all fives and ones
    run_req(8'd3, 1'b0);
    vectors++; if (n_coins !== 0 || done_cyc !== 2) begin errors++; $display("FAIL inv3_flow: got coins %0d cyc %0d expected 0 2", n_coins, done_cyc); end
    vectors++; if (short !== 1'b1 || remaining !== 8'd3) begin errors++; $display("FAIL inv3_short: got short %0b rem %0d expected 1 3", short, remaining); end
    tick();
    vectors++; if (short !== 1'b0) begin errors++; $display("FAIL inv3_idle_short: got %0b expected 0", short); end
  endtask
`endif

  task automatic test_reset_mid();
    coin_ready = 1'b0;
    req_valid  = 1'b1;
    req_amount = 8'd10;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++; if (coin_valid !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL rm_issue: got valid %0b state %0d expected 1 2", coin_valid, state); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (coin_valid !== 1'b0 || state !== 3'd0 || coin_out !== 8'd0) begin
      errors++; $display("FAIL rm_async: got valid %0b state %0d coin %0d expected 0 0 0", coin_valid, state, coin_out);
    end
    vectors++; if (remaining !== 8'd0 || coin_total !== 8'd0) begin errors++; $display("FAIL rm_counts: got %0d/%0d expected 0/0", remaining, coin_total); end
    #1 reset = 1'b1;
    coin_ready = 1'b1;
    tick();
    vectors++; if (coin_valid !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL rm_abandon: got valid %0b state %0d expected 0 0", coin_valid, state); end
    run_req(8'd10, 1'b0);
    vectors++; if (n_coins !== 1 || coin_log[0] !== 8'd10) begin errors++; $display("FAIL rm_new_coin: got n %0d coin %0d expected 1 10", n_coins, coin_log[0]); end
    vectors++; if (done_cyc !== 3 || coin_total !== 8'd1 || remaining !== 8'd0) begin
      errors++; $display("FAIL rm_new_done: got cyc %0d total %0d rem %0d expected 3 1 0", done_cyc, coin_total, remaining);
    end
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_amount = 8'd0;
    coin_ready = 1'b0;
    test_reset();
    test_zero();
    test_greedy_66();
    test_stall_15();
`ifdef CHANGE_INVENTORY_EN
    test_inventory();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INV_INIT, default 8'd20: per-denomination coin stock loaded at reset (used only with CHANGE_INVENTORY_EN).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  change request present.
REQ-005 req_amount  input  8  change to pay out, in money units.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 coin_valid  output  1  coin_out holds a coin for the hopper.
REQ-008 coin_out  output  8  coin value: 50, 10, 5 or 1; 0 when coin_valid low.
REQ-009 coin_ready  input  1  hopper accepts the presented coin.
REQ-010 done  output  1  one-cycle pulse when a request completes.
REQ-011 short  output  1  exact change impossible; valid with done.
REQ-012 remaining  output  8  change still owed.
REQ-013 coin_total  output  8  coins issued for the current request.
REQ-014 state  output  3  current FSM state.

Function
REQ-015 States SHALL be IDLE=0, SELECT=1, ISSUE=2, DONE=3; any other value SHALL go to IDLE next cycle.
REQ-016 IDLE: req_ready=1 and all other control outputs 0.
REQ-017 IDLE with req_valid: latch req_amount into remaining, clear coin_total and short, go to SELECT; req_amount=0 goes directly to DONE.
REQ-018 SELECT: pick the largest denomination in {50, 10, 5, 1} that is <= remaining, drive it on coin_out with coin_valid=1, and go to ISSUE.
REQ-019 ISSUE: coin_out and coin_valid SHALL stay stable until coin_ready=1.
REQ-020 ISSUE handshake (coin_valid and coin_ready): remaining -= coin_out and coin_total += 1 in the same cycle; go to DONE if the new remaining is 0, else SELECT.
REQ-021 coin_valid SHALL drop to 0 in SELECT and DONE; each coin costs at least 2 cycles.
REQ-022 DONE: done=1 for exactly one cycle; remaining and coin_total hold their final values; then go to IDLE.
REQ-023 req_valid outside IDLE SHALL be ignored.
REQ-024 Latency: request accept to done = 1 + 2*N cycles when coin_ready is held high (N = coins issued), and 1 cycle for amount 0.
REQ-025 Arithmetic SHALL be unsigned 8-bit; remaining never underflows because the selected coin is always <= remaining.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE.
REQ-027 Asserting reset SHALL immediately force coin_valid=0, coin_out=0, done=0, short=0, remaining=0 and coin_total=0.
REQ-028 Reset mid-request SHALL abandon the request; owed change is lost and no coin is presented after reset.
REQ-029 With CHANGE_INVENTORY_EN, reset SHALL reload every stock counter to INV_INIT.

Configuration
REQ-030 Macro CHANGE_INVENTORY_EN defined: per-denomination 8-bit stock counters are compiled in.
- SELECT skips denominations whose stock is 0.
- Each handshake decrements the stock of the issued denomination.
- If no stocked denomination is <= remaining, go to DONE with short=1 and remaining left unpaid.
REQ-031 Macro CHANGE_INVENTORY_EN undefined: stock is unlimited, no counters exist, and short is tied to 0.

Structure
REQ-032 Shared package change_pkg SHALL hold the state encodings and the coin value constants (50, 10, 5, 1), also used by the vending-machine block.
REQ-033 Sub-module coin_selector (combinational): inputs remaining and per-denomination available flags; outputs the chosen coin value and a none-found flag.

Verification
REQ-034 req_amount=0 -> done pulses 1 cycle after accept; coin_valid never asserts; coin_total=0.
REQ-035 req_amount=66, coin_ready held 1 -> coins 50, 10, 5, 1 in order; done at cycle 9 after accept; coin_total=4; remaining=0.
REQ-036 req_amount=15, coin_ready low for 3 cycles on the first coin -> coin_out=10 held stable through the stall, then 5; done; coin_total=2.
REQ-037 CHANGE_INVENTORY_EN, 50-stock=0, req_amount=60 -> six coins of 10; done with short=0.
REQ-038 CHANGE_INVENTORY_EN, 1-stock=0 and 5-stock=0, req_amount=3 -> no coin issued; done with short=1; remaining=3.
REQ-039 Reset asserted in ISSUE with coin_ready low -> coin_valid=0 and state=0 before the next edge; new request of 10 afterwards completes normally.
